// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Brief    : Shared types and helpers for the router packetizer.
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_PARITY  = 3'd4,
        ST_GAP     = 3'd5
    } tx_state_e;

    function automatic logic [7:0] pack_header(input logic [LEN_W-1:0]  len,
                                               input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_buf
// Brief    : Single-packet payload store, synchronous write, combinational read.
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_buf
    import router_pkg::*;
#(
    parameter int DEPTH = 63
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [LEN_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (int'(rd_addr) < DEPTH) ? r_mem[rd_addr] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_tx
// Brief    : Buffers one payload packet and replays it as header/payload/parity
//            on the router datain/packet_valid interface, honouring busy.
//            Define PKT_TX_STATS_EN to add tx_pkt_cnt/drop_cnt statistics ports.
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic [1:0]  s_addr,
    input  logic        s_last,
    input  logic        busy,
    output logic [7:0]  datain,
    output logic        packet_valid,
    output logic        drop,
    output logic        trunc
`ifdef PKT_TX_STATS_EN
    ,
    output logic [15:0] tx_pkt_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam logic [LEN_W-1:0] c_max_len  = LEN_W'(MAX_LEN);
    localparam logic [15:0]      c_gap_last = 16'(GAP_CYCLES - 1);

    tx_state_e         r_state;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_reuse_addr;
    logic              r_hdr_pend;
    logic [7:0]        r_parity;
    logic [15:0]       r_gap;
    logic [7:0]        r_datain;
    logic              r_pkt_valid;
    logic              r_drop;
    logic              r_trunc;

    logic              w_accept;
    logic              w_close;
    logic              w_drop_close;
    logic [LEN_W-1:0]  w_cnt_next;
    logic [LEN_W-1:0]  w_wr_addr;
    logic [ADDR_W-1:0] w_addr_cur;
    logic [7:0]        w_rd_data;
    logic [7:0]        w_hdr_live;
    logic [7:0]        w_hdr_stored;

    assign s_ready      = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
    assign w_accept     = s_valid & s_ready;
    // A packet following a truncation keeps the address of the truncated one.
    assign w_addr_cur   = ((r_state == ST_IDLE) && !r_reuse_addr) ? s_addr : r_addr;
    assign w_cnt_next   = (r_state == ST_IDLE) ? LEN_W'(1) : r_cnt + LEN_W'(1);
    assign w_wr_addr    = (r_state == ST_IDLE) ? '0 : r_cnt;
    assign w_close      = w_accept & (s_last | (w_cnt_next == c_max_len));
    assign w_drop_close = w_close & (w_addr_cur == ADDR_INVALID);
    assign w_hdr_live   = pack_header(w_cnt_next, w_addr_cur);
    assign w_hdr_stored = pack_header(r_cnt, r_addr);

    router_pkt_buf #(
        .DEPTH   (MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .wr_en   (w_accept),
        .wr_addr (w_wr_addr),
        .wr_data (s_data),
        .rd_addr (r_idx),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_addr       <= '0;
            r_reuse_addr <= 1'b0;
            r_hdr_pend   <= 1'b0;
            r_parity     <= 8'h00;
            r_gap        <= '0;
            r_datain     <= 8'h00;
            r_pkt_valid  <= 1'b0;
            r_drop       <= 1'b0;
            r_trunc      <= 1'b0;
        end else begin
            r_drop  <= 1'b0;
            r_trunc <= 1'b0;
            case (r_state)
                ST_IDLE, ST_COLLECT: begin
                    if (w_accept) begin
                        r_cnt        <= w_cnt_next;
                        r_addr       <= w_addr_cur;
                        r_reuse_addr <= 1'b0;
                        r_state      <= ST_COLLECT;
                        if (w_close) begin
                            r_trunc      <= ~s_last;
                            r_reuse_addr <= ~s_last;
                            if (w_drop_close) begin
                                r_drop  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_state    <= ST_HEADER;
                                r_idx      <= '0;
                                // Header waits in HEADER if the router is busy now.
                                r_hdr_pend <= busy;
                                if (!busy) begin
                                    r_datain    <= w_hdr_live;
                                    r_pkt_valid <= 1'b1;
                                    r_parity    <= w_hdr_live;
                                end
                            end
                        end
                    end
                end
                ST_HEADER: begin
                    if (!busy) begin
                        if (r_hdr_pend) begin
                            r_datain    <= w_hdr_stored;
                            r_pkt_valid <= 1'b1;
                            r_parity    <= w_hdr_stored;
                            r_hdr_pend  <= 1'b0;
                        end else begin
                            r_datain <= w_rd_data;
                            r_parity <= r_parity ^ w_rd_data;
                            r_idx    <= r_idx + LEN_W'(1);
                            r_state  <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (!busy) begin
                        if (r_idx == r_cnt) begin
                            r_datain    <= r_parity;
                            r_pkt_valid <= 1'b0;
                            r_state     <= ST_PARITY;
                        end else begin
                            r_datain <= w_rd_data;
                            r_parity <= r_parity ^ w_rd_data;
                            r_idx    <= r_idx + LEN_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        r_datain    <= 8'h00;
                        r_pkt_valid <= 1'b0;
                        r_gap       <= '0;
                        r_state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!busy) begin
                        if (r_gap == c_gap_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_gap <= r_gap + 16'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign datain       = r_datain;
    assign packet_valid = r_pkt_valid;
    assign drop         = r_drop;
    assign trunc        = r_trunc;

`ifdef PKT_TX_STATS_EN
    logic [15:0] r_tx_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if ((r_state == ST_PARITY) && !busy && (r_tx_cnt != 16'hFFFF)) begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
            if (w_drop_close && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign tx_pkt_cnt = r_tx_cnt;
    assign drop_cnt   = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_tx
// Brief    : Directed and randomized bench for router_pkt_tx against a
//            message-level reference model (PKT_TX_STATS_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

    localparam int MAX_LEN    = 63;
    localparam int GAP_CYCLES = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic [1:0] s_addr = 2'd0;
    logic       s_last = 1'b0;
    logic       busy = 1'b0;
    logic [7:0] datain;
    logic       packet_valid;
    logic       drop;
    logic       trunc;
`ifdef PKT_TX_STATS_EN
    logic [15:0] tx_pkt_cnt;
    logic [15:0] drop_cnt;
`endif

    router_pkt_tx #(
        .MAX_LEN      (MAX_LEN),
        .GAP_CYCLES   (GAP_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_addr       (s_addr),
        .s_last       (s_last),
        .busy         (busy),
        .datain       (datain),
        .packet_valid (packet_valid),
        .drop         (drop),
        .trunc        (trunc)
`ifdef PKT_TX_STATS_EN
        ,
        .tx_pkt_cnt   (tx_pkt_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_bytes[$];
    int         exp_flen[$];
    logic [7:0] frame_q[$];
    logic [7:0] hdr_seen[$];
    int  exp_drops = 0, exp_trunc = 0, drop_seen = 0, trunc_seen = 0;
    int  exp_tx_since = 0, exp_drop_since = 0;
    bit  busy_rand = 1'b0;
    bit  in_frame = 1'b0, expect_gap = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: a message splits into chunks of at most MAX_LEN bytes sharing one address.
    task automatic model_submit(input logic [1:0] addr);
        int n, len;
        logic [7:0] hdr, par;
        n = tx_q.size();
        for (int s = 0; s < n; s += MAX_LEN) begin
            len = (n - s > MAX_LEN) ? MAX_LEN : n - s;
            if (addr == 2'd3) begin
                exp_drops++;
                exp_drop_since++;
            end else begin
                hdr = {len[5:0], addr};
                par = hdr;
                exp_bytes.push_back(hdr);
                for (int i = 0; i < len; i++) begin
                    exp_bytes.push_back(tx_q[s + i]);
                    par = par ^ tx_q[s + i];
                end
                exp_bytes.push_back(par);
                exp_flen.push_back(len + 2);
                exp_tx_since++;
            end
            if (s + len < n) exp_trunc++;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [1:0] a, input logic l);
        int guard;
        guard = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_addr  = a;
        s_last  = l;
        while (!s_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) check("sready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [1:0] addr, input bit bubbles);
        model_submit(addr);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (bubbles) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(tx_q[i], (i == 0) ? addr : 2'($urandom_range(0, 3)), i == tx_q.size() - 1);
        end
    endtask

    task automatic fill_rand(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_flen.size() != 0 || in_frame || expect_gap) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 32'(exp_flen.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic end_frame();
        int L, bad;
        logic [7:0] e, got;
        hdr_seen.push_back(frame_q[0]);
        if (exp_flen.size() == 0) begin
            check("unexpected_frame", 32'(frame_q.size()), 32'd0);
        end else begin
            L = exp_flen.pop_front();
            bad = 0;
            check("frame_len", 32'(frame_q.size()), 32'(L));
            for (int i = 0; i < L; i++) begin
                e = exp_bytes.pop_front();
                got = (i < frame_q.size()) ? frame_q[i] : ~e;
                if (i == 0) check("header", 32'(got), 32'(e));
                else if (i == L - 1) check("parity", 32'(got), 32'(e));
                else if (got !== e) bad++;
            end
            check("payload_bytes_bad", 32'(bad), 32'd0);
        end
        frame_q.delete();
    endtask

    // A byte is delivered in every cycle the router is not busy.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame   = 1'b0;
                expect_gap = 1'b0;
                frame_q.delete();
            end else if (!busy) begin
                if (packet_valid) begin
                    in_frame = 1'b1;
                    frame_q.push_back(datain);
                end else if (in_frame) begin
                    frame_q.push_back(datain);
                    in_frame   = 1'b0;
                    expect_gap = 1'b1;
                    end_frame();
                end else if (expect_gap) begin
                    check("gap_idle", 32'({packet_valid, datain}), 32'd0);
                    expect_gap = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (drop)  drop_seen++;
            if (trunc) trunc_seen++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy_rand) busy = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] seq [6];
        int guard, hold, ds0, ts0, n;
        logic [1:0] a;
        seq[0] = 9'h1AA; seq[1] = 9'h1BB; seq[2] = 9'h1CC;
        seq[3] = 9'h1DD; seq[4] = 9'h011; seq[5] = 9'h000;

        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_datain", 32'(datain), 32'd0);
        check("rst_packet_valid", 32'(packet_valid), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_trunc", 32'(trunc), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic four-byte packet, cycle by cycle
        tx_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_msg(2'd1, 1'b0);
        check("t1_header", 32'({packet_valid, datain}), 32'h111);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("t1_seq", 32'({packet_valid, datain}), 32'(seq[k]));
        end
        @(posedge clk);
        #1;
        check("t1_s_ready", 32'(s_ready), 32'd1);
        wait_drain();

        // Busy held for three cycles while BB is on the bus
        send_msg(2'd1, 1'b0);
        guard = 0;
        while (!(packet_valid && datain == 8'hBB) && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        busy = 1'b1;
        hold = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (packet_valid && datain == 8'hBB) hold++;
        end
        busy = 1'b0;
        check("busy_hold_cycles", 32'(hold), 32'd4);
        @(posedge clk);
        #1;
        check("after_hold", 32'({packet_valid, datain}), 32'h1CC);
        wait_drain();

        // Invalid destination
        ds0 = drop_seen;
        tx_q = {8'h12, 8'h34};
        send_msg(2'd3, 1'b0);
        repeat (3) @(negedge clk);
        check("drop_pulses", 32'(drop_seen - ds0), 32'd1);
        check("drop_s_ready", 32'(s_ready), 32'd1);

        // 70 bytes: truncation at MAX_LEN, remainder reuses address
        ts0 = trunc_seen;
        fill_rand(70);
        send_msg(2'd2, 1'b0);
        wait_drain();
        check("trunc_pulses", 32'(trunc_seen - ts0), 32'd1);
        check("trunc_hdr0", 32'(hdr_seen[hdr_seen.size() - 2]), 32'hFE);
        check("trunc_hdr1", 32'(hdr_seen[hdr_seen.size() - 1]), 32'h1E);

        // Reset in the middle of the payload
        tx_q.delete();
        for (int i = 0; i < 10; i++) tx_q.push_back(8'(8'h10 + i));
        send_msg(2'd1, 1'b0);
        guard = 0;
        while (!(packet_valid && datain == 8'h12) && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_packet_valid", 32'(packet_valid), 32'd0);
        check("rst_mid_datain", 32'(datain), 32'd0);
        n = exp_flen.pop_front();
        repeat (n) void'(exp_bytes.pop_front());
        exp_tx_since   = 0;
        exp_drop_since = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_s_ready", 32'(s_ready), 32'd1);
        tx_q = {8'h5A, 8'hA5, 8'h3C};
        send_msg(2'd2, 1'b0);
        check("post_rst_header", 32'({packet_valid, datain}), 32'h10E);
        wait_drain();

        // Randomized traffic with random busy
        busy_rand = 1'b1;
        for (int m = 0; m < 40; m++) begin
            n = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 130) : $urandom_range(1, 16);
            a = 2'($urandom_range(0, 3));
            fill_rand(n);
            send_msg(a, 1'b1);
        end
        wait_drain();
        busy_rand = 1'b0;
        @(posedge clk);
        #1;
        busy = 1'b0;
        repeat (4) @(negedge clk);
        check("drop_total", 32'(drop_seen), 32'(exp_drops));
        check("trunc_total", 32'(trunc_seen), 32'(exp_trunc));
`ifdef PKT_TX_STATS_EN
        check("tx_pkt_cnt", 32'(tx_pkt_cnt), 32'(exp_tx_since));
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop_since));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
